// File: rtl/imem_arbiter_if.sv
// Request/response bundle between the instruction-memory arbiter and its two requesters
// (IF-stage fetch and program loader/debug).
//   master : requester side, drives request fields, receives ready and responses
//   slave  : arbiter side, receives requests, drives ready and responses
// Fetch:  f_req_valid/f_req_addr -> f_req_ready; f_rsp_valid/f_rsp_data/f_rsp_err
// Loader: l_req_valid/l_req_we/l_req_addr/l_req_wdata/l_lock -> l_req_ready;
//         l_rsp_valid/l_rsp_data/l_rsp_err
interface imem_arbiter_if;
  logic        f_req_valid;
  logic [31:0] f_req_addr;
  logic        f_req_ready;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_data;
  logic        f_rsp_err;

  logic        l_req_valid;
  logic        l_req_we;
  logic [31:0] l_req_addr;
  logic [31:0] l_req_wdata;
  logic        l_lock;
  logic        l_req_ready;
  logic        l_rsp_valid;
  logic [31:0] l_rsp_data;
  logic        l_rsp_err;

  modport master (
    output f_req_valid, f_req_addr,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output l_req_valid, l_req_we, l_req_addr, l_req_wdata, l_lock,
    input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err
  );

  modport slave (
    input  f_req_valid, f_req_addr,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  l_req_valid, l_req_we, l_req_addr, l_req_wdata, l_lock,
    output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter/sequencer. Shares one synchronous-read, word-addressed
// memory between the IF-stage fetch port and the loader/debug port, issuing at most one access
// per cycle and returning each response to its owner one cycle after the grant.
// Loader wins contention, but after LOADER_BURST_MAX consecutive loader grants with fetch
// waiting, fetch gets one slot. l_lock moves the arbiter to LOCKED, where only the loader is
// served.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     fetch and loader request/response handshakes
//   locked          arbiter is in LOCKED
//   mem_en/mem_we   memory access / write enable
//   mem_addr        word address (byte address bits [WORD_AW+1:2], upper bits wrap)
//   mem_wdata       write data
//   mem_rdata       read data, valid the cycle after a read
// Optional: define IMEM_ARB_ALIGN_CHECK_EN to reject misaligned requests with an error
// response instead of issuing them.
module imem_arbiter #(
  parameter int unsigned WORD_AW          = 11,
  parameter int unsigned LOADER_BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  imem_arbiter_if.slave      bus,
  output logic               locked,
  output logic               mem_en,
  output logic               mem_we,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  localparam int unsigned CntW = $clog2(LOADER_BURST_MAX + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(LOADER_BURST_MAX);

  typedef enum logic [0:0] {StRun, StLocked} state_e;
  typedef enum logic [1:0] {OwnNone, OwnF, OwnL} owner_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  owner_e          rsp_owner_q, rsp_owner_d;
  // Response data forced to 0 (loader write, or rejected misaligned access).
  logic            rsp_zero_q, rsp_zero_d;

  logic        f_grant, l_grant, any_grant, grant_mis, issue;
  logic [31:0] grant_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (bus.l_lock)  state_d = StLocked;
      StLocked: if (!bus.l_lock) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // Output logic: at most one ready; nothing is accepted while reset is asserted.
  always_comb begin
    locked          = (state_q == StLocked);
    bus.f_req_ready = 1'b0;
    bus.l_req_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (bus.f_req_valid && (!bus.l_req_valid || burst_cnt_q == BurstMax)) begin
            bus.f_req_ready = 1'b1;
          end else begin
            bus.l_req_ready = bus.l_req_valid;
          end
        end
        StLocked: bus.l_req_ready = bus.l_req_valid;
        default: ;
      endcase
    end
  end

  assign f_grant    = bus.f_req_valid & bus.f_req_ready;
  assign l_grant    = bus.l_req_valid & bus.l_req_ready;
  assign any_grant  = f_grant | l_grant;
  assign grant_addr = f_grant ? bus.f_req_addr : (l_grant ? bus.l_req_addr : 32'h0);

  // Upper address bits wrap; the low two only matter with the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{grant_addr[31:WORD_AW+2], grant_addr[1:0]};

  // Memory drive
  always_comb begin
    issue     = any_grant & ~grant_mis;
    mem_en    = issue;
    mem_we    = issue & l_grant & bus.l_req_we;
    mem_addr  = issue ? grant_addr[WORD_AW+1:2] : '0;
    mem_wdata = (issue && l_grant && bus.l_req_we) ? bus.l_req_wdata : 32'h0;
  end

  // Burst counter: counts loader grants taken while fetch waits; never runs in LOCKED.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == StLocked || state_d == StLocked || !bus.f_req_valid || f_grant) begin
      burst_cnt_d = '0;
    end else if (l_grant && burst_cnt_q != BurstMax) begin
      burst_cnt_d = burst_cnt_q + CntW'(1);
    end
  end

  // Response owner capture
  always_comb begin
    rsp_owner_d = f_grant ? OwnF : (l_grant ? OwnL : OwnNone);
    rsp_zero_d  = grant_mis | (l_grant & bus.l_req_we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q <= '0;
      rsp_owner_q <= OwnNone;
      rsp_zero_q  <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  // Response routing: read data passes straight through from the memory.
  always_comb begin
    bus.f_rsp_valid = (rsp_owner_q == OwnF);
    bus.l_rsp_valid = (rsp_owner_q == OwnL);
    bus.f_rsp_data  = (bus.f_rsp_valid && !rsp_zero_q) ? mem_rdata : 32'h0;
    bus.l_rsp_data  = (bus.l_rsp_valid && !rsp_zero_q) ? mem_rdata : 32'h0;
  end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  logic rsp_err_q;

  // Misaligned requests are accepted but not issued; they answer with an error.
  assign grant_mis = any_grant & (grant_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= grant_mis;
    end
  end

  assign bus.f_rsp_err = bus.f_rsp_valid & rsp_err_q;
  assign bus.l_rsp_err = bus.l_rsp_valid & rsp_err_q;
`else
  assign grant_mis     = 1'b0;
  assign bus.f_rsp_err = 1'b0;
  assign bus.l_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: table of per-cycle vectors with expected readies/lock state, a
// reference memory image and a queue of expected responses (one entry per cycle).
module tb_imem_arbiter;
  localparam int unsigned WordAw   = 11;
  localparam int unsigned BurstMax = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              locked, mem_en, mem_we;
  logic [WordAw-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  imem_arbiter_if bus ();

  imem_arbiter #(
    .WORD_AW          (WordAw),
    .LOADER_BURST_MAX (BurstMax)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .locked    (locked),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory seen by the DUT, and the bench's own reference image.
  logic [31:0] mem     [2048];
  logic [31:0] ref_mem [2048];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    string       nm;
    logic        fv;
    logic [31:0] fa;
    logic        lv;
    logic        lwe;
    logic [31:0] la;
    logic [31:0] lwd;
    logic        lk;
    logic        frdy;
    logic        lrdy;
    logic        lkd;
  } vec_t;

  typedef struct {
    logic        fv;
    logic        lv;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  vec_t tbl[$];
  rsp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(string nm, logic fv, logic [31:0] fa, logic lv, logic lwe,
                              logic [31:0] la, logic [31:0] lwd, logic lk,
                              logic frdy, logic lrdy, logic lkd);
    vec_t v;
    v.nm = nm; v.fv = fv; v.fa = fa; v.lv = lv; v.lwe = lwe; v.la = la; v.lwd = lwd;
    v.lk = lk; v.frdy = frdy; v.lrdy = lrdy; v.lkd = lkd;
    return v;
  endfunction

  function automatic rsp_t none_rsp();
    rsp_t r;
    r.fv = 1'b0; r.lv = 1'b0; r.err = 1'b0; r.data = 32'h0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.f_req_valid = v.fv;
    bus.f_req_addr  = v.fa;
    bus.l_req_valid = v.lv;
    bus.l_req_we    = v.lwe;
    bus.l_req_addr  = v.la;
    bus.l_req_wdata = v.lwd;
    bus.l_lock      = v.lk;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".f_req_ready"}, {31'h0, bus.f_req_ready}, 32'h0);
    chk({tag, ".l_req_ready"}, {31'h0, bus.l_req_ready}, 32'h0);
    chk({tag, ".f_rsp_valid"}, {31'h0, bus.f_rsp_valid}, 32'h0);
    chk({tag, ".l_rsp_valid"}, {31'h0, bus.l_rsp_valid}, 32'h0);
    chk({tag, ".f_rsp_data"},  bus.f_rsp_data, 32'h0);
    chk({tag, ".l_rsp_data"},  bus.l_rsp_data, 32'h0);
    chk({tag, ".rsp_err"},     {30'h0, bus.f_rsp_err, bus.l_rsp_err}, 32'h0);
    chk({tag, ".locked"},      {31'h0, locked}, 32'h0);
    chk({tag, ".mem_en_we"},   {30'h0, mem_en, mem_we}, 32'h0);
    chk({tag, ".mem_addr"},    {21'h0, mem_addr}, 32'h0);
    chk({tag, ".mem_wdata"},   mem_wdata, 32'h0);
  endtask

  // Drive one cycle (called at posedge+1), check at the falling edge, queue the response.
  task automatic apply(input vec_t v);
    rsp_t        e, nx;
    logic        gf, gl, mis, iss;
    logic [31:0] a;
    int          idx;
    drive(v);
    #4;
    gf  = v.fv & v.frdy;
    gl  = v.lv & v.lrdy;
    a   = gf ? v.fa : (gl ? v.la : 32'h0);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    mis = (gf | gl) && (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    iss = (gf | gl) & ~mis;
    idx = int'(a[12:2]);
    chk({v.nm, ".f_req_ready"}, {31'h0, bus.f_req_ready}, {31'h0, v.frdy});
    chk({v.nm, ".l_req_ready"}, {31'h0, bus.l_req_ready}, {31'h0, v.lrdy});
    chk({v.nm, ".locked"},      {31'h0, locked}, {31'h0, v.lkd});
    chk({v.nm, ".mem_en"},      {31'h0, mem_en}, {31'h0, iss});
    chk({v.nm, ".mem_we"},      {31'h0, mem_we}, {31'h0, iss & gl & v.lwe});
    chk({v.nm, ".mem_addr"},    {21'h0, mem_addr}, iss ? {21'h0, a[12:2]} : 32'h0);
    chk({v.nm, ".mem_wdata"},   mem_wdata, (iss && gl && v.lwe) ? v.lwd : 32'h0);

    if (sb.size() == 0) e = none_rsp();
    else                e = sb.pop_front();
    chk({v.nm, ".f_rsp_valid"}, {31'h0, bus.f_rsp_valid}, {31'h0, e.fv});
    chk({v.nm, ".l_rsp_valid"}, {31'h0, bus.l_rsp_valid}, {31'h0, e.lv});
    if (e.fv) begin
      chk({v.nm, ".f_rsp_data"}, bus.f_rsp_data, e.data);
      chk({v.nm, ".f_rsp_err"},  {31'h0, bus.f_rsp_err}, {31'h0, e.err});
    end
    if (e.lv) begin
      chk({v.nm, ".l_rsp_data"}, bus.l_rsp_data, e.data);
      chk({v.nm, ".l_rsp_err"},  {31'h0, bus.l_rsp_err}, {31'h0, e.err});
    end

    nx      = none_rsp();
    nx.fv   = gf;
    nx.lv   = gl;
    nx.err  = mis;
    if (mis || !(gf | gl) || (gl && v.lwe)) nx.data = 32'h0;
    else                                     nx.data = ref_mem[idx];
    if (iss && gl && v.lwe) ref_mem[idx] = v.lwd;
    sb.push_back(nx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = 32'hC0DE_0000 + i;
      ref_mem[i] = 32'hC0DE_0000 + i;
    end
    mem[5]     = 32'h0050_0093;
    ref_mem[5] = 32'h0050_0093;
    mem[8]     = 32'h0080_0113;
    ref_mem[8] = 32'h0080_0113;

    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Outputs stay 0 during reset even with both requesters valid.
    rst = 1'b1;
    drive(mk("rst", 1, 32'h14, 1, 1, 32'h40, 32'h1, 0, 0, 0, 0));
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle);
    sb.push_back(none_rsp());

    //          name        fv fa            lv we la          lwd            lk fr lr lkd
    tbl.push_back(mk("lone_fetch", 1, 32'h14,   0, 0, 0,        0,             0, 1, 0, 0));
    tbl.push_back(mk("lone_lrd",   0, 0,        1, 0, 32'h20,   0,             0, 0, 1, 0));
    tbl.push_back(mk("lwr",        0, 0,        1, 1, 32'h80,   32'h1234_5678, 0, 0, 1, 0));
    tbl.push_back(mk("lrd_raw",    0, 0,        1, 0, 32'h80,   0,             0, 0, 1, 0));
    tbl.push_back(mk("fetch_wrap", 1, 32'h2014, 0, 0, 0,        0,             0, 1, 0, 0));
    tbl.push_back(mk("fetch_mis",  1, 32'h22,   0, 0, 0,        0,             0, 1, 0, 0));
    tbl.push_back(idle);
    // Starvation bound: L,L,L,L,F,L,L,L,L,F
    for (int i = 0; i < 10; i++) begin
      tbl.push_back(mk($sformatf("starve%0d", i), 1, 32'h100, 1, 0, 32'h200 + 4 * i, 0, 0,
                       (i % 5) == 4, (i % 5) != 4, 0));
    end
    tbl.push_back(idle);
    // A cycle without fetch valid clears the burst count.
    tbl.push_back(mk("clr_a", 1, 32'h104, 1, 0, 32'h300, 0, 0, 0, 1, 0));
    tbl.push_back(mk("clr_b", 1, 32'h104, 1, 0, 32'h304, 0, 0, 0, 1, 0));
    tbl.push_back(mk("clr_c", 0, 0,       1, 0, 32'h308, 0, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk($sformatf("clr_d%0d", i), 1, 32'h104, 1, 0, 32'h30C, 0, 0,
                       i == 4, i != 4, 0));
    end
    tbl.push_back(idle);
    // Lock: fetch granted in the l_lock cycle, its response arrives while LOCKED.
    tbl.push_back(mk("lk_f",    1, 32'h14, 0, 0, 0,     0,             1, 1, 0, 0));
    tbl.push_back(mk("lk_wr",   1, 32'h14, 1, 1, 32'h40, 32'hDEAD_BEEF, 1, 0, 1, 1));
    tbl.push_back(mk("lk_rd",   1, 32'h14, 1, 0, 32'h40, 0,             1, 0, 1, 1));
    tbl.push_back(mk("lk_hold", 1, 32'h14, 0, 0, 0,     0,             1, 0, 0, 1));
    tbl.push_back(mk("unlk0",   1, 32'h14, 0, 0, 0,     0,             0, 0, 0, 1));
    tbl.push_back(mk("unlk1",   1, 32'h14, 0, 0, 0,     0,             0, 1, 0, 0));
    tbl.push_back(idle);
    // l_lock with both valid in RUN: normal arbitration that cycle.
    tbl.push_back(mk("lkb",     1, 32'h18, 1, 0, 32'h44, 0, 1, 0, 1, 0));
    tbl.push_back(mk("lkb_out", 1, 32'h18, 0, 0, 0,      0, 0, 0, 0, 1));
    tbl.push_back(idle);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset in the cycle after a fetch grant drops the in-flight response.
    apply(mk("pre_rst", 1, 32'h14, 0, 0, 0, 0, 0, 1, 0, 0));
    rst = 1'b1;
    #4;
    chk_all_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle);
    sb.delete();
    sb.push_back(none_rsp());
    apply(mk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("post_f", 1, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0));
    apply(idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
